// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle MIPS-subset CPU.
// Steps the shared datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// drives per-state control lines and waits on the memory ready handshake.
// Optional retired-instruction counter: define MCCTRL_PERF_EN to add the
// `retired` output and its counter.
module multicycle_control_fsm #(
  parameter logic [2:0] RESET_STATE = 3'd0  // FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src,
  output logic [2:0] alu_cntrl,
  output logic       illegal,
  output logic       busy
`ifdef MCCTRL_PERF_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ILLEGAL, I_ADD, I_ADDU, I_SLT, I_JR,
    I_ADDI, I_ADDIU, I_BEQ, I_BNE, I_LW, I_SW, I_J, I_JAL
  } instr_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd3;

  // Map an opcode/funct pair onto the supported instruction set.
  function automatic instr_t classify(input logic [5:0] op, input logic [5:0] fn);
    instr_t kind;
    kind = I_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  kind = I_ADD;
          FN_ADDU: kind = I_ADDU;
          FN_SLT:  kind = I_SLT;
          FN_JR:   kind = I_JR;
          default: kind = I_ILLEGAL;
        endcase
      end
      OP_J:     kind = I_J;
      OP_JAL:   kind = I_JAL;
      OP_BEQ:   kind = I_BEQ;
      OP_BNE:   kind = I_BNE;
      OP_ADDI:  kind = I_ADDI;
      OP_ADDIU: kind = I_ADDIU;
      OP_LW:    kind = I_LW;
      OP_SW:    kind = I_SW;
      default:  kind = I_ILLEGAL;
    endcase
    return kind;
  endfunction

  state_t     state;
  state_t     next_state;
  logic [5:0] op_q;
  logic [5:0] funct_q;
  instr_t     dec_instr;  // from the live IR fields, used while in DECODE
  instr_t     cur_instr;  // from the fields latched at the end of DECODE

  assign dec_instr = classify(opcode, funct);
  assign cur_instr = classify(op_q, funct_q);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= state_t'(RESET_STATE);
    else        state <= next_state;
  end

  // Capture the instruction fields while DECODE examines them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      funct_q <= '0;
    end else if (state == DECODE) begin
      op_q    <= opcode;
      funct_q <= funct;
    end
  end

  // Next-state selection.
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (run && mem_ready) next_state = DECODE;
      end
      DECODE: begin
        case (dec_instr)
          I_J, I_JAL, I_JR, I_ILLEGAL: next_state = FETCH;
          default:                     next_state = EXECUTE;
        endcase
      end
      EXECUTE: begin
        case (cur_instr)
          I_ADD, I_ADDU, I_SLT, I_ADDI, I_ADDIU: next_state = WRITEBACK;
          I_LW, I_SW:                            next_state = MEMORY;
          default:                               next_state = FETCH;
        endcase
      end
      MEMORY: begin
        if (cur_instr != I_LW && cur_instr != I_SW) next_state = FETCH;
        else if (mem_ready) next_state = (cur_instr == I_LW) ? WRITEBACK : FETCH;
      end
      WRITEBACK: next_state = FETCH;
      default:   next_state = FETCH;
    endcase
  end

  // Per-state control decode; everything is forced low while reset is held
  // so a high `run` cannot raise a request during reset.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 2'd0;
    reg_wr     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src    = 2'd0;
    alu_cntrl  = ALU_ADD;
    illegal    = 1'b0;
    busy       = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          if (run) begin
            mem_rd = 1'b1;
            busy   = 1'b1;
            if (mem_ready) begin
              ir_wr  = 1'b1;
              pc_wr  = 1'b1;
              pc_src = 2'd0;
            end
          end
        end
        DECODE: begin
          busy = 1'b1;
          case (dec_instr)
            I_J: begin
              pc_wr  = 1'b1;
              pc_src = 2'd2;
            end
            I_JAL: begin
              pc_wr      = 1'b1;
              pc_src     = 2'd2;
              reg_wr     = 1'b1;
              reg_dst    = 2'd2;
              mem_to_reg = 2'd2;
            end
            I_JR: begin
              pc_wr  = 1'b1;
              pc_src = 2'd3;
            end
            I_ILLEGAL: illegal = 1'b1;
            default: ;
          endcase
        end
        EXECUTE: begin
          busy = 1'b1;
          case (cur_instr)
            I_ADD, I_ADDU: alu_cntrl = ALU_ADD;
            I_SLT:         alu_cntrl = ALU_SLT;
            I_ADDI, I_ADDIU, I_LW, I_SW: begin
              alu_src   = 2'd1;
              alu_cntrl = ALU_ADD;
            end
            I_BEQ: begin
              alu_cntrl = ALU_SUB;
              pc_src    = 2'd1;
              pc_wr     = zero;
            end
            I_BNE: begin
              alu_cntrl = ALU_SUB;
              pc_src    = 2'd1;
              pc_wr     = ~zero;
            end
            default: ;
          endcase
        end
        MEMORY: begin
          busy   = 1'b1;
          mem_rd = (cur_instr == I_LW);
          mem_wr = (cur_instr == I_SW);
        end
        WRITEBACK: begin
          busy   = 1'b1;
          reg_wr = 1'b1;
          case (cur_instr)
            I_ADD, I_ADDU, I_SLT: reg_dst = 2'd1;
            I_LW:                 mem_to_reg = 2'd1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef MCCTRL_PERF_EN
  logic        retire;
  logic [31:0] retired_q;

  // Flag the final cycle of every legal instruction.
  always_comb begin
    retire = 1'b0;
    case (state)
      DECODE:    retire = (dec_instr == I_J) || (dec_instr == I_JAL) || (dec_instr == I_JR);
      EXECUTE:   retire = (cur_instr == I_BEQ) || (cur_instr == I_BNE);
      MEMORY:    retire = (cur_instr == I_SW) && mem_ready;
      WRITEBACK: retire = 1'b1;
      default:   retire = 1'b0;
    endcase
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Inputs change just after the
// falling edge; outputs are sampled 1 time unit later, away from the rising edge.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_rd, mem_wr, ir_wr, pc_wr, reg_wr, illegal, busy;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src;
  logic [2:0] alu_cntrl;
`ifdef MCCTRL_PERF_EN
  logic [31:0] retired;
`endif

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src;
    logic [2:0] alu_cntrl;
    logic       illegal;
    logic       busy;
  } ctl_t;

  ctl_t obs;
  ctl_t e;
  int   total = 0;
  int   bad   = 0;

  assign obs = {mem_rd, mem_wr, ir_wr, pc_wr, pc_src, reg_wr, reg_dst,
                mem_to_reg, alu_src, alu_cntrl, illegal, busy};

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ir_wr      (ir_wr),
    .pc_wr      (pc_wr),
    .pc_src     (pc_src),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_cntrl  (alu_cntrl),
    .illegal    (illegal),
    .busy       (busy)
`ifdef MCCTRL_PERF_EN
    ,
    .retired    (retired)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic ctl_t c_idle();
    return '0;
  endfunction

  function automatic ctl_t c_busy();
    ctl_t c;
    c = '0;
    c.busy = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_fetch(input logic rdy);
    ctl_t c;
    c = c_busy();
    c.mem_rd = 1'b1;
    c.ir_wr  = rdy;
    c.pc_wr  = rdy;
    return c;
  endfunction

  // One clock: apply mem_ready for this cycle, then compare all controls.
  task automatic cyc(input string tag, input logic rdy, input ctl_t want);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check(tag, 32'(obs), 32'(want));
  endtask

  // FETCH cycle that also presents a new instruction word with run=1.
  task automatic start(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy);
    @(negedge clk);
    opcode    = op;
    funct     = fn;
    run       = 1'b1;
    mem_ready = rdy;
    #1;
    check(tag, 32'(obs), 32'(c_fetch(rdy)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

    // Reset held, even with run high: every output low.
    #12;
    check("reset_outputs", 32'(obs), 32'(c_idle()));
`ifdef MCCTRL_PERF_EN
    check("reset_retired", retired, 32'd0);
`endif
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("idle_after_reset", 1'b1, c_idle());

    // add: 4 cycles with zero-wait memory.
    start("add_fetch", 6'b000000, 6'b100000, 1'b1);
    cyc("add_decode", 1'b1, c_busy());
    cyc("add_exec", 1'b1, c_busy());
    e = c_busy(); e.reg_wr = 1'b1; e.reg_dst = 2'd1;
    cyc("add_wb", 1'b1, e);

    // slt back-to-back.
    start("slt_fetch", 6'b000000, 6'b101010, 1'b1);
`ifdef MCCTRL_PERF_EN
    check("retired_after_add", retired, 32'd1);
`endif
    cyc("slt_decode", 1'b1, c_busy());
    e = c_busy(); e.alu_cntrl = 3'd3;
    cyc("slt_exec", 1'b1, e);
    e = c_busy(); e.reg_wr = 1'b1; e.reg_dst = 2'd1;
    cyc("slt_wb", 1'b1, e);

    // addi: funct field must be ignored for I-type.
    start("addi_fetch", 6'b001000, 6'b111111, 1'b1);
    cyc("addi_decode", 1'b1, c_busy());
    e = c_busy(); e.alu_src = 2'd1;
    cyc("addi_exec", 1'b1, e);
    e = c_busy(); e.reg_wr = 1'b1;
    cyc("addi_wb", 1'b1, e);

    // lw: 2 wait cycles in FETCH, 3 in MEMORY -> 10 cycles; run dropped mid-way.
    start("lw_fetch_wait0", 6'b100011, 6'b000000, 1'b0);
    cyc("lw_fetch_wait1", 1'b0, c_fetch(1'b0));
    cyc("lw_fetch_ready", 1'b1, c_fetch(1'b1));
    cyc("lw_decode", 1'b0, c_busy());
    run = 1'b0;
    e = c_busy(); e.alu_src = 2'd1;
    cyc("lw_exec", 1'b0, e);
    e = c_busy(); e.mem_rd = 1'b1;
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, e);
    cyc("lw_mem_ready", 1'b1, e);
    e = c_busy(); e.reg_wr = 1'b1; e.mem_to_reg = 2'd1;
    cyc("lw_wb", 1'b0, e);
    cyc("lw_then_idle", 1'b1, c_idle());
`ifdef MCCTRL_PERF_EN
    check("retired_after_lw", retired, 32'd4);
`endif

    // beq taken (zero=1).
    zero = 1'b1;
    start("beq_fetch", 6'b000100, 6'b000000, 1'b1);
    cyc("beq_decode", 1'b1, c_busy());
    e = c_busy(); e.alu_cntrl = 3'd1; e.pc_src = 2'd1; e.pc_wr = 1'b1;
    cyc("beq_exec_taken", 1'b1, e);

    // bne with zero=1: not taken.
    start("bne_fetch", 6'b000101, 6'b000000, 1'b1);
    cyc("bne_decode", 1'b1, c_busy());
    e = c_busy(); e.alu_cntrl = 3'd1; e.pc_src = 2'd1;
    cyc("bne_exec_not_taken", 1'b1, e);

    // bne with zero=0: taken.
    start("bne2_fetch", 6'b000101, 6'b000000, 1'b1);
    cyc("bne2_decode", 1'b1, c_busy());
    zero = 1'b0;
    e = c_busy(); e.alu_cntrl = 3'd1; e.pc_src = 2'd1; e.pc_wr = 1'b1;
    cyc("bne2_exec_taken", 1'b1, e);

    // jal: resolved in DECODE.
    start("jal_fetch", 6'b000011, 6'b000000, 1'b1);
    e = c_busy(); e.pc_wr = 1'b1; e.pc_src = 2'd2; e.reg_wr = 1'b1;
    e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
    cyc("jal_decode", 1'b1, e);

    // jr: resolved in DECODE.
    start("jr_fetch", 6'b000000, 6'b001000, 1'b1);
    e = c_busy(); e.pc_wr = 1'b1; e.pc_src = 2'd3;
    cyc("jr_decode", 1'b1, e);

    // Unsupported opcode and unsupported R-type funct.
    start("ill_op_fetch", 6'b111111, 6'b000000, 1'b1);
    e = c_busy(); e.illegal = 1'b1;
    cyc("ill_op_decode", 1'b1, e);
    start("ill_fn_fetch", 6'b000000, 6'b100010, 1'b1);
    cyc("ill_fn_decode", 1'b1, e);
    run = 1'b0;
    cyc("ill_then_idle", 1'b1, c_idle());
`ifdef MCCTRL_PERF_EN
    check("retired_skip_illegal", retired, 32'd9);
`endif

    // sw completing with zero-wait memory.
    start("sw_fetch", 6'b101011, 6'b000000, 1'b1);
    cyc("sw_decode", 1'b1, c_busy());
    e = c_busy(); e.alu_src = 2'd1;
    cyc("sw_exec", 1'b1, e);
    e = c_busy(); e.mem_wr = 1'b1;
    cyc("sw_mem_ready", 1'b1, e);

    // Second sw, aborted by reset while waiting in MEMORY.
    start("sw2_fetch", 6'b101011, 6'b000000, 1'b1);
`ifdef MCCTRL_PERF_EN
    check("retired_after_sw", retired, 32'd10);
`endif
    cyc("sw2_decode", 1'b1, c_busy());
    e = c_busy(); e.alu_src = 2'd1;
    cyc("sw2_exec", 1'b1, e);
    e = c_busy(); e.mem_wr = 1'b1;
    cyc("sw2_mem_wait", 1'b0, e);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drops_mem_wr", 32'(obs), 32'(c_idle()));
`ifdef MCCTRL_PERF_EN
    check("async_reset_retired", retired, 32'd0);
`endif
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    cyc("idle_after_abort", 1'b1, c_idle());
`ifdef MCCTRL_PERF_EN
    check("retired_after_abort", retired, 32'd0);
`endif

    // Restart from FETCH after the abort.
    start("post_abort_fetch", 6'b000010, 6'b000000, 1'b1);
    e = c_busy(); e.pc_wr = 1'b1; e.pc_src = 2'd2;
    cyc("post_abort_j_decode", 1'b1, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
